// File: rtl/nanorisc_mem_pkg.sv
// Shared types and constants for the NanoRisc data memory arbiter.
// Optional build macro used by this block: DATA_MEM_ARB_ROUND_ROBIN_EN.
package nanorisc_mem_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 8;
    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned NUM_PORTS      = 2;

    // Requester id: 0 = core load/store path, 1 = debug/loader port
    typedef logic [0:0] portId_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arbState_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between the two request ports.
// DATA_MEM_ARB_ROUND_ROBIN_EN defined: on a tie the port not granted most
// recently wins. Undefined: fixed priority, port 0 wins every tie.
module mem_arb_picker (
    input  logic p0Req,
    input  logic p1Req,
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    input  logic lastGnt,
`endif
    output logic anyReq,
    output logic winner
);

    // Pick the winning port; a lone requester always wins
    always_comb begin
        anyReq = p0Req | p1Req;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        if (p0Req && p1Req) begin
            winner = ~lastGnt;
        end else begin
            winner = p0Req ? 1'b0 : 1'b1;
        end
`else
        winner = p0Req ? 1'b0 : 1'b1;
`endif
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter/sequencer for the NanoRisc 8-bit data memory.
// Serialises port 0 (load/store) and port 1 (debug/loader) requests onto the
// single memory interface. Build macro: DATA_MEM_ARB_ROUND_ROBIN_EN selects
// round-robin tie-breaking; otherwise port 0 has fixed priority.
module data_memory_arbiter
    import nanorisc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              p0Req,
    input  logic              p0We,
    input  logic [ADDR_W-1:0] p0Addr,
    input  logic [DATA_W-1:0] p0WData,
    input  logic              p1Req,
    input  logic              p1We,
    input  logic [ADDR_W-1:0] p1Addr,
    input  logic [DATA_W-1:0] p1WData,
    output logic              p0Gnt,
    output logic              p1Gnt,
    output logic              p0RValid,
    output logic              p1RValid,
    output logic [DATA_W-1:0] p0RData,
    output logic [DATA_W-1:0] p1RData,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] memDataOut
);

    arbState_t         state_q, state_d;
    logic              grant;
    logic              anyReq;
    logic              winner;

    logic              cmdWe_q;
    portId_t           cmdPort_q;
    logic [ADDR_W-1:0] cmdAddr_q;
    logic [DATA_W-1:0] cmdWData_q;

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    logic              lastGnt_q;
`endif

    mem_arb_picker uPicker (
        .p0Req   (p0Req),
        .p1Req   (p1Req),
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        .lastGnt (lastGnt_q),
`endif
        .anyReq  (anyReq),
        .winner  (winner)
    );

    // Memory address/data always come from the latched command
    assign memAddress   = cmdAddr_q;
    assign memWriteData = cmdWData_q;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grants, memory strobes and read return
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        p0Gnt    = 1'b0;
        p1Gnt    = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        p0RValid = 1'b0;
        p1RValid = 1'b0;
        p0RData  = '0;
        p1RData  = '0;
        case (state_q)
            IDLE: begin
                // reset_n gating keeps Gnt low while reset is held with Req high
                if (anyReq && reset_n) begin
                    grant   = 1'b1;
                    p0Gnt   = (winner == 1'b0);
                    p1Gnt   = (winner == 1'b1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                memWrite = cmdWe_q;
                memRead  = ~cmdWe_q;
                state_d  = cmdWe_q ? IDLE : RESP;
            end
            RESP: begin
                if (cmdPort_q == 1'b0) begin
                    p0RValid = 1'b1;
                    p0RData  = memDataOut;
                end else begin
                    p1RValid = 1'b1;
                    p1RData  = memDataOut;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command register: capture the winner's request on grant
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmdWe_q    <= 1'b0;
            cmdPort_q  <= 1'b0;
            cmdAddr_q  <= '0;
            cmdWData_q <= '0;
        end else if (grant) begin
            cmdPort_q  <= winner;
            cmdWe_q    <= winner ? p1We    : p0We;
            cmdAddr_q  <= winner ? p1Addr  : p0Addr;
            cmdWData_q <= winner ? p1WData : p0WData;
        end
    end

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    // Last-grant pointer; starts at port 1 so port 0 wins the first tie
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lastGnt_q <= 1'b1;
        end else if (grant) begin
            lastGnt_q <= winner;
        end
    end
`endif

endmodule
